// File: rtl/fir_filter_tdm_multichannel.sv
// fir_filter_tdm_multichannel
//   Time-multiplexed multichannel FIR filter. L multiply-accumulate lanes are
//   shared by NUM_CH independent channels. Each channel has its own N-entry
//   circular delay line. One coefficient set is shared by all channels and can
//   be rewritten at run time. The output is rounded, saturated and delivered
//   through a valid/ready handshake.
//
//   Handshake semantics (both interfaces): a transfer happens on the rising
//   edge where valid and ready are both high. out_valid, out_data, out_ch and
//   out_sat are held stable until out_ready accepts them. in_ready is high only
//   in IDLE.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   in_data/in_ch/in_valid/in_ready  sample input stream tagged with a channel
//   coef_wr_en/addr/data            coefficient write port (taken in IDLE only)
//   out_data/out_ch/out_sat         filtered sample, its channel, clip flag
//   out_valid/out_ready             output handshake
//   err                             one-cycle pulse: dropped coef write or bad in_ch
module fir_filter_tdm_multichannel #(
  parameter int N          = 211,
  parameter int IN_WIDTH   = 16,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int NUM_CH     = 4,
  parameter int L          = 2,
  localparam int PTR_W     = $clog2(N),
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [IN_WIDTH-1:0]   in_data,
  input  logic [CH_W-1:0]              in_ch,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         coef_wr_en,
  input  logic [PTR_W-1:0]             coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sat,
  output logic                         err
);

  localparam int K     = (N + L - 1) / L;
  localparam int TAP_W = $clog2(N + L);
  localparam int PW    = IN_WIDTH + COEF_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] RND_C = ACC_WIDTH'(1) << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH-1:0] OMAX  =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OMIN  =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;
  state_t state, state_next;

  logic signed [IN_WIDTH-1:0]   dline [NUM_CH][N];
  logic signed [COEF_WIDTH-1:0] coef  [N];
  logic [PTR_W-1:0]             wr_ptr [NUM_CH];

  logic [PTR_W-1:0]             cnt;
  logic [PTR_W-1:0]             rd_ptr;    // delay-line address of x[n-j*L]
  logic [TAP_W-1:0]             tap_base;  // j*L for the current MAC cycle
  logic [CH_W-1:0]              cur_ch;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic accept, ch_ok, accept_ok;

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  // Extra MSB keeps the range check meaningful when NUM_CH is a power of two.
  assign ch_ok     = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));
  assign accept_ok = accept && ch_ok;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (cnt == PTR_W'(N - 1)) state_next = S_IDLE;
      S_IDLE:  if (accept_ok) state_next = S_MAC;
      S_MAC:   if (cnt == PTR_W'(K - 1)) state_next = S_ROUND;
      S_ROUND: state_next = S_OUT;
      S_OUT:   if (out_ready) state_next = S_IDLE;
      default: state_next = S_CLEAR;
    endcase
  end

  // MAC lanes: lane l handles tap k = j*L + l, reading x[n-k] from the
  // circular delay line. Taps past N-1 (last partial group) contribute 0.
  logic signed [ACC_WIDTH-1:0] mac_sum;
  logic [TAP_W-1:0]            tap;
  logic [PTR_W-1:0]            idx;
  logic [PTR_W-1:0]            cidx;
  logic signed [PW-1:0]        prod;

  always_comb begin
    mac_sum = '0;
    tap     = '0;
    idx     = '0;
    cidx    = '0;
    prod    = '0;
    for (int l = 0; l < L; l++) begin
      tap  = tap_base + TAP_W'(l);
      idx  = (rd_ptr >= PTR_W'(l)) ? rd_ptr - PTR_W'(l) : rd_ptr + PTR_W'(N - l);
      cidx = tap[PTR_W-1:0];
      prod = dline[cur_ch][idx] * coef[cidx];
      if (tap < TAP_W'(N))
        mac_sum = mac_sum + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    end
  end

  // Round-half-up, arithmetic shift, then clip to the output range.
  logic signed [ACC_WIDTH-1:0] rnd, shifted;
  logic signed [OUT_WIDTH-1:0] y;
  logic                        y_sat;

  always_comb begin
    rnd     = acc + RND_C;
    shifted = rnd >>> SHIFT;
    y       = shifted[OUT_WIDTH-1:0];
    y_sat   = 1'b0;
    if (shifted > OMAX) begin
      y     = OMAX[OUT_WIDTH-1:0];
      y_sat = 1'b1;
    end else if (shifted < OMIN) begin
      y     = OMIN[OUT_WIDTH-1:0];
      y_sat = 1'b1;
    end
  end

  // Storage. CLEAR wipes one address per cycle in every delay line and in
  // the coefficient table. A coefficient write on the same edge as a sample
  // accept lands before the first MAC cycle reads it.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      coef[cnt] <= '0;
      for (int c = 0; c < NUM_CH; c++) dline[c][cnt] <= '0;
    end else if (!rst && state == S_IDLE) begin
      if (coef_wr_en) coef[coef_wr_addr] <= coef_wr_data;
      if (accept_ok)  dline[in_ch][wr_ptr[in_ch]] <= in_data;
    end
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rd_ptr    <= '0;
      tap_base  <= '0;
      cur_ch    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
      err       <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) wr_ptr[c] <= '0;
    end else begin
      err <= 1'b0;
      cnt <= (state_next != state) ? '0 : cnt + 1'b1;
      case (state)
        S_CLEAR: begin
          for (int c = 0; c < NUM_CH; c++) wr_ptr[c] <= '0;
        end
        S_IDLE: begin
          if (accept && !ch_ok) err <= 1'b1;
          if (accept_ok) begin
            cur_ch        <= in_ch;
            rd_ptr        <= wr_ptr[in_ch];
            wr_ptr[in_ch] <= (wr_ptr[in_ch] == PTR_W'(N - 1)) ? '0 : wr_ptr[in_ch] + 1'b1;
            acc           <= '0;
            tap_base      <= '0;
          end
        end
        S_MAC: begin
          acc      <= acc + mac_sum;
          tap_base <= tap_base + TAP_W'(L);
          rd_ptr   <= (rd_ptr >= PTR_W'(L)) ? rd_ptr - PTR_W'(L) : rd_ptr + PTR_W'(N - L);
        end
        S_ROUND: begin
          out_data  <= y;
          out_sat   <= y_sat;
          out_ch    <= cur_ch;
          out_valid <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
      if (coef_wr_en && state != S_IDLE) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_filter_tdm_multichannel.sv
// tb_fir_filter_tdm_multichannel
//   Directed bench for the TDM multichannel FIR. A small reference model
//   (per-channel history, coefficient table, round/saturate) produces the
//   expected output of every accepted sample, pushed onto exp_q at drive time
//   and popped by a monitor whenever the DUT completes an output transfer.
//   Built with a short filter (N=13, odd so the last MAC group is partial)
//   and three channels so an out-of-range channel index is reachable.
module tb_fir_filter_tdm_multichannel;

  localparam int N      = 13;
  localparam int L      = 2;
  localparam int NUM_CH = 3;
  localparam int K      = (N + L - 1) / L;
  localparam int SHIFT  = 15;
  localparam int PTR_W  = $clog2(N);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int W      = CH_W + 1 + 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0]      in_data = '0;
  logic [CH_W-1:0]  in_ch = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             coef_wr_en = 1'b0;
  logic [PTR_W-1:0] coef_wr_addr = '0;
  logic [15:0]      coef_wr_data = '0;
  logic [15:0]      out_data;
  logic [CH_W-1:0]  out_ch;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_sat;
  logic             err;

  fir_filter_tdm_multichannel #(
    .N(N), .IN_WIDTH(16), .COEF_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(16),
    .SHIFT(SHIFT), .NUM_CH(NUM_CH), .L(L)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_ch(in_ch), .in_valid(in_valid), .in_ready(in_ready),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .out_sat(out_sat), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  int err_exp = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state
  int coef_m [N];
  int hist [NUM_CH][N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_out(input int ch);
    longint s;
    logic [15:0] y;
    logic sat;
    s = 0;
    for (int k = 0; k < N; k++) s += longint'(coef_m[k]) * longint'(hist[ch][k]);
    s = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    sat = 1'b0;
    if (s > 32767) begin
      s = 32767;
      sat = 1'b1;
    end else if (s < -32768) begin
      s = -32768;
      sat = 1'b1;
    end
    y = 16'(s);
    return {CH_W'(ch), sat, y};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      coef_m[k] = 0;
      for (int c = 0; c < NUM_CH; c++) hist[c][k] = 0;
    end
  endtask

  // Scoreboard monitor: a transfer happens on the next edge when both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_output: got %0h expected none", {out_ch, out_sat, out_data});
      end
      if (exp_q.size() != 0) check("out", 32'({out_ch, out_sat, out_data}), 32'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) if (err === 1'b1) err_seen++;

  // Driver tasks
  task automatic wait_idle();
    int t = 0;
    @(posedge clk); #1;
    while (!in_ready && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input int ch, input logic [15:0] d, input bit wr = 1'b0,
                      input int k = 0, input logic [15:0] v = '0);
    wait_idle();
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    in_data  = d;
    if (wr) begin
      coef_wr_en   = 1'b1;
      coef_wr_addr = PTR_W'(k);
      coef_wr_data = v;
      coef_m[k]    = int'($signed(v));
    end
    if (ch < NUM_CH) begin
      for (int i = N - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
      hist[ch][0] = int'($signed(d));
      exp_q.push_back(model_out(ch));
    end else begin
      err_exp++;
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    coef_wr_en = 1'b0;
  endtask

  task automatic wcoef(input int k, input logic [15:0] v);
    wait_idle();
    coef_wr_en   = 1'b1;
    coef_wr_addr = PTR_W'(k);
    coef_wr_data = v;
    coef_m[k]    = int'($signed(v));
    @(posedge clk); #1;
    coef_wr_en = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Called just after rst is released: CLEAR keeps in_ready low for N cycles.
  task automatic clear_check();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("clear_in_ready", 32'(in_ready), 32'd0);
      check("clear_out_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check("idle_after_clear", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_check();

    // 1: impulse on ch0 with c[k]=2*(k+1) gives outputs 1..N
    for (int k = 0; k < N; k++) wcoef(k, 16'(2 * (k + 1)));
    send(0, 16'h4000);
    // out_valid rises K+1 edges after the accept edge: K+2 negedges later.
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(K + 2));
    for (int i = 1; i < N; i++) send(0, 16'h0000);
    drain();

    // 2: ch2 impulse interleaved with full-scale ch1 samples
    for (int i = 0; i < N; i++) begin
      send(2, (i == 0) ? 16'h4000 : 16'h0000);
      send(1, 16'h7FFF);
    end
    drain();

    // 3: saturation, positive then negative
    for (int k = 0; k < N; k++) wcoef(k, 16'h7FFF);
    for (int i = 0; i < N + 2; i++) send(0, 16'h7FFF);
    for (int i = 0; i < N + 2; i++) send(0, 16'h8000);
    drain();

    // 4: backpressure holds the result and blocks input
    out_ready = 1'b0;
    send(2, 16'h0100);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold", 32'({out_ch, out_sat, out_data}), 32'(exp_q[0]));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_one_transfer", 32'(out_valid), 32'd0);
    check("bp_queue", 32'(exp_q.size()), 32'd0);

    // 5: coefficient write during MAC is dropped; bad channel is dropped
    send(1, 16'h0010);
    coef_wr_en   = 1'b1;
    coef_wr_addr = '0;
    coef_wr_data = 16'h0005;
    err_exp++;
    @(posedge clk); #1;
    coef_wr_en = 1'b0;
    @(negedge clk);
    check("err_drop_wr", 32'(err), 32'd1);
    @(negedge clk);
    check("err_pulse_end", 32'(err), 32'd0);
    drain();
    send(1, 16'h0020);
    drain();
    send(NUM_CH, 16'h1234);
    @(negedge clk);
    check("err_bad_ch", 32'(err), 32'd1);
    check("bad_ch_idle", 32'(in_ready), 32'd1);
    repeat (K + 4) @(negedge clk);
    check("bad_ch_no_out", 32'(out_valid), 32'd0);

    // 6: reset mid-MAC discards the result and reruns CLEAR
    send(0, 16'h4000);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_clear();
    clear_check();
    send(0, 16'h4000);
    for (int i = 1; i < N; i++) send(0, 16'h0000);
    drain();
    // coefficient write on the same edge as a sample accept is used at once
    send(1, 16'h4000, 1'b1, 0, 16'h0002);
    drain();

    repeat (3) @(negedge clk);
    check("err_count", 32'(err_seen), 32'(err_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
